// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: parity modes, FSM encoding, sizing helper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // 50 MHz system clock / 115200 baud, rounded.
    localparam int CLKS_PER_BIT_115200 = 434;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // Ceiling log2; clog2(1) = 0. Loop bound keeps 1<<i positive.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Circular-buffer FIFO queueing words for the UART transmitter.
// Latency: a push is visible on dout/empty the edge after it is written.
// Backpressure: push while full and pop while empty are ignored; no overwrite.
// Ports: clk/rst_n; push+din write side; pop+dout read side (dout is the head word);
//        full/empty flags and count of stored words.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic                    pop,
    input  logic [WIDTH-1:0]        din,
    output logic [WIDTH-1:0]        dout,
    output logic                    full,
    output logic                    empty,
    output logic [clog2(DEPTH):0]   count
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

    // DEPTH is a power of two, so pointers wrap naturally at AW bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter (baud, data bits, parity, stop bits) fed by a small FIFO.
// Latency: word accepted at edge N drives the start bit from edge N+2; queued frames follow with no gap.
// Backpressure: TX_READY is a registered !full; TX_VALID while TX_READY is low is ignored.
// Ports: CLOCK/RESET_N; TX_VALID/TX_DATA/TX_READY upstream handshake; O_TX_SERIAL line (idle high);
//        O_TX_BUSY frame in progress; O_TX_DONE last-clock pulse; FIFO_COUNT words waiting.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = PARITY_NONE,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                         CLOCK,
    input  logic                         RESET_N,
    input  logic                         TX_VALID,
    input  logic [DATA_BITS-1:0]         TX_DATA,
    output logic                         TX_READY,
    output logic                         O_TX_SERIAL,
    output logic                         O_TX_BUSY,
    output logic                         O_TX_DONE,
    output logic [clog2(FIFO_DEPTH):0]   FIFO_COUNT
);

    localparam int BAUD_W = clog2(CLKS_PER_BIT);
    localparam int BIT_W  = clog2(DATA_BITS + 1);
    localparam int CNT_W  = clog2(FIFO_DEPTH) + 1;

    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535 ||
        DATA_BITS < 5 || DATA_BITS > 9 ||
        PARITY_MODE < 0 || PARITY_MODE > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2 ||
        FIFO_DEPTH < 2 || FIFO_DEPTH > 64 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
        $error("uart_tx_param: illegal parameter combination");
    end

    tx_state_e             state_q, state_d;
    logic [BAUD_W-1:0]     baud_q, baud_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic                  par_q, par_d;
    logic                  serial_q, serial_d;
    logic                  busy_q, done_q, ready_q;

    logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [DATA_BITS-1:0]  fifo_dout;
    logic [CNT_W-1:0]      fifo_count, fifo_count_nxt;
    logic                  baud_last, frame_end, load;

    assign fifo_push = TX_VALID && ready_q && !fifo_full;

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLOCK),
        .rst_n (RESET_N),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (TX_DATA),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Occupancy after this edge; lets TX_READY be a register yet still drop the
    // cycle right after the accept that fills the FIFO.
    always_comb begin
        fifo_count_nxt = fifo_count;
        if (fifo_push && !fifo_pop)      fifo_count_nxt = fifo_count + 1'b1;
        else if (fifo_pop && !fifo_push) fifo_count_nxt = fifo_count - 1'b1;
    end

    assign baud_last = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        par_d     = par_q;
        frame_end = 1'b0;
        load      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) load = 1'b1;
            end
            ST_START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = ST_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (baud_last) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_W'(DATA_BITS - 1)) begin
                        bit_d   = '0;
                        state_d = (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            ST_PARITY: begin
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = ST_STOP;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            ST_STOP: begin
                // bit_q counts stop bits here.
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == BIT_W'(STOP_BITS - 1)) begin
                        frame_end = 1'b1;
                        bit_d     = '0;
                        if (!fifo_empty) load = 1'b1;
                        else             state_d = ST_IDLE;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Pop and start a frame, either from IDLE or straight out of the last stop bit.
        if (load) begin
            shift_d = fifo_dout;
            par_d   = (PARITY_MODE == PARITY_ODD) ? ~^fifo_dout : ^fifo_dout;
            bit_d   = '0;
            baud_d  = '0;
            state_d = ST_START;
        end
    end

    assign fifo_pop = load;

    // Line level decoded from the current state and registered once more, so every
    // output lags the FSM by one clock uniformly.
    always_comb begin
        serial_d = 1'b1;
        case (state_q)
            ST_START:  serial_d = 1'b0;
            ST_DATA:   serial_d = shift_q[0];
            ST_PARITY: serial_d = par_q;
            default:   serial_d = 1'b1;
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= ST_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            serial_q <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            serial_q <= serial_d;
            busy_q   <= (state_q != ST_IDLE);
            done_q   <= frame_end;
            ready_q  <= (fifo_count_nxt != CNT_W'(FIFO_DEPTH));
        end
    end

    assign TX_READY    = ready_q;
    assign O_TX_SERIAL = serial_q;
    assign O_TX_BUSY   = busy_q;
    assign O_TX_DONE   = done_q;
    assign FIFO_COUNT  = fifo_count;

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: 8N1 instance plus 7E2 and 7O2 instances, CLKS_PER_BIT=4.
// Latency: samples outputs 1 ns after each rising edge; k counts edges after the first push edge.
// Backpressure: upstream valid is held until accepted where the scenario needs it.
module tb_uart_tx_param;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       v8 = 1'b0;
    logic [7:0] d8 = 8'h00;
    logic       r8, s8, b8, dn8;
    logic [2:0] c8;

    logic       ve = 1'b0;
    logic [6:0] de = 7'h00;
    logic       re, se, be, dne;
    logic [2:0] ce;

    logic       vo = 1'b0;
    logic [6:0] d7o = 7'h00;
    logic       ro, so, bo, dno;
    logic [2:0] co;

    int checks = 0;
    int passed = 0;
    logic [7:0] exp_words [8];

    uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut8 (
        .CLOCK(clk), .RESET_N(rst_n), .TX_VALID(v8), .TX_DATA(d8), .TX_READY(r8),
        .O_TX_SERIAL(s8), .O_TX_BUSY(b8), .O_TX_DONE(dn8), .FIFO_COUNT(c8));

    uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_e (
        .CLOCK(clk), .RESET_N(rst_n), .TX_VALID(ve), .TX_DATA(de), .TX_READY(re),
        .O_TX_SERIAL(se), .O_TX_BUSY(be), .O_TX_DONE(dne), .FIFO_COUNT(ce));

    uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_o (
        .CLOCK(clk), .RESET_N(rst_n), .TX_VALID(vo), .TX_DATA(d7o), .TX_READY(ro),
        .O_TX_SERIAL(so), .O_TX_BUSY(bo), .O_TX_DONE(dno), .FIFO_COUNT(co));

    // Expected line level idx clocks after the start bit begins (4 clocks per bit).
    function automatic logic exp_bit(int idx, logic [7:0] data, int nbits, bit par_en, logic par);
        int b;
        if (idx < 0) return 1'b1;
        b = idx / 4;
        if (b == 0) return 1'b0;
        if (b <= nbits) return data[b-1];
        if (par_en && b == nbits + 1) return par;
        return 1'b1;
    endfunction

    // Expected 8N1 line for nfr contiguous frames from exp_words, first start bit at k=2.
    function automatic logic exp_stream(int k, int nfr);
        int rel;
        int f;
        rel = k - 2;
        if (rel < 0) return 1'b1;
        f = rel / 40;
        if (f >= nfr) return 1'b1;
        return exp_bit(rel % 40, exp_words[f], 8, 1'b0, 1'b0);
    endfunction

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (s8 !== 1'b1) $display("FAIL reset_serial got %b want 1", s8); else passed++;
        checks++; if (b8 !== 1'b0) $display("FAIL reset_busy got %b want 0", b8); else passed++;
        checks++; if (dn8 !== 1'b0) $display("FAIL reset_done got %b want 0", dn8); else passed++;
        checks++; if (c8 !== 3'd0) $display("FAIL reset_count got %0d want 0", c8); else passed++;
        checks++; if ({r8, re, ro} !== 3'b000) $display("FAIL reset_ready got %b want 000", {r8, re, ro}); else passed++;
        rst_n = 1'b1;
        #1;
        checks++; if (r8 !== 1'b0) $display("FAIL release_ready_before_edge got %b want 0", r8); else passed++;
        @(posedge clk); #1;
        checks++; if ({r8, re, ro} !== 3'b111) $display("FAIL release_ready_after_edge got %b want 111", {r8, re, ro}); else passed++;
        checks++; if ({ce, co} !== 6'd0) $display("FAIL release_count_7bit got %b want 0", {ce, co}); else passed++;
    endtask

    task automatic test_single();
        int errs = 0, bad_k = -1, busy_n = 0, done_n = 0, done_k = -1, first_low = -1;
        logic want, bad_got = 1'b0, bad_want = 1'b0;
        for (int k = 0; k < 50; k++) begin
            v8 = (k == 0);
            d8 = 8'h53;
            @(posedge clk); #1;
            if (k == 0) begin
                checks++; if (c8 !== 3'd1) $display("FAIL single_count_after_push got %0d want 1", c8); else passed++;
            end
            if (k == 1) begin
                checks++; if (c8 !== 3'd0) $display("FAIL single_count_after_pop got %0d want 0", c8); else passed++;
            end
            want = exp_bit(k - 2, 8'h53, 8, 1'b0, 1'b0);
            if (s8 !== want) begin
                if (errs == 0) begin bad_k = k; bad_got = s8; bad_want = want; end
                errs++;
            end
            if (s8 === 1'b0 && first_low < 0) first_low = k;
            if (b8 === 1'b1) busy_n++;
            if (dn8 === 1'b1) begin done_n++; done_k = k; end
        end
        v8 = 1'b0;
        checks++; if (first_low != 2) $display("FAIL single_start_latency got edge N+%0d want N+2", first_low); else passed++;
        checks++; if (errs != 0) $display("FAIL single_line %0d bad cycles, first k=%0d got %b want %b", errs, bad_k, bad_got, bad_want); else passed++;
        checks++; if (busy_n != 40) $display("FAIL single_busy_clocks got %0d want 40", busy_n); else passed++;
        checks++; if (done_n != 1) $display("FAIL single_done_pulses got %0d want 1", done_n); else passed++;
        checks++; if (done_k != 41) $display("FAIL single_done_position got k=%0d want 41", done_k); else passed++;
    endtask

    task automatic test_back_to_back();
        int errs = 0, bad_k = -1, busy_n = 0, done_n = 0, peak = 0;
        logic want, bad_got = 1'b0, bad_want = 1'b0;
        exp_words[0] = 8'h53; exp_words[1] = 8'h4D; exp_words[2] = 8'h01; exp_words[3] = 8'h08;
        for (int k = 0; k < 176; k++) begin
            v8 = (k < 4);
            d8 = exp_words[(k < 4) ? k : 0];
            @(posedge clk); #1;
            if (int'(c8) > peak) peak = int'(c8);
            want = exp_stream(k, 4);
            if (s8 !== want) begin
                if (errs == 0) begin bad_k = k; bad_got = s8; bad_want = want; end
                errs++;
            end
            if (b8 === 1'b1) busy_n++;
            if (dn8 === 1'b1) done_n++;
        end
        v8 = 1'b0;
        checks++; if (errs != 0) $display("FAIL b2b_line %0d bad cycles, first k=%0d got %b want %b", errs, bad_k, bad_got, bad_want); else passed++;
        checks++; if (busy_n != 160) $display("FAIL b2b_busy_clocks got %0d want 160", busy_n); else passed++;
        checks++; if (done_n != 4) $display("FAIL b2b_done_pulses got %0d want 4", done_n); else passed++;
        checks++; if (peak != 3) $display("FAIL b2b_count_peak got %0d want 3", peak); else passed++;
    endtask

    task automatic test_fifo_full();
        int errs = 0, bad_k = -1, idx = 0;
        logic want, acc, bad_got = 1'b0, bad_want = 1'b0;
        for (int i = 0; i < 6; i++) exp_words[i] = 8'hA1 + 8'(i);
        for (int k = 0; k < 252; k++) begin
            v8  = (idx < 6);
            d8  = exp_words[(idx < 6) ? idx : 0];
            acc = v8 && (r8 === 1'b1);
            @(posedge clk); #1;
            if (acc) idx++;
            if (k == 4) begin
                checks++; if (idx != 5) $display("FAIL full_accepts_before_stall got %0d want 5", idx); else passed++;
                checks++; if (r8 !== 1'b0) $display("FAIL full_ready_drop got %b want 0", r8); else passed++;
                checks++; if (c8 !== 3'd4) $display("FAIL full_count got %0d want 4", c8); else passed++;
            end
            if (k == 41) begin
                checks++; if (idx != 5) $display("FAIL full_held_off got %0d accepts want 5", idx); else passed++;
                checks++; if (r8 !== 1'b1) $display("FAIL full_ready_return got %b want 1", r8); else passed++;
            end
            if (k == 42) begin
                checks++; if (idx != 6) $display("FAIL full_sixth_accept got %0d want 6", idx); else passed++;
                checks++; if (c8 !== 3'd4) $display("FAIL full_count_refill got %0d want 4", c8); else passed++;
            end
            want = exp_stream(k, 6);
            if (s8 !== want) begin
                if (errs == 0) begin bad_k = k; bad_got = s8; bad_want = want; end
                errs++;
            end
        end
        v8 = 1'b0;
        checks++; if (errs != 0) $display("FAIL full_line %0d bad cycles, first k=%0d got %b want %b", errs, bad_k, bad_got, bad_want); else passed++;
    endtask

    task automatic test_parity();
        int errs_e = 0, errs_o = 0, busy_e = 0, busy_o = 0, done_ke = -1, done_ko = -1;
        for (int k = 0; k < 52; k++) begin
            ve = (k == 0); de = 7'h41;
            vo = (k == 0); d7o = 7'h41;
            @(posedge clk); #1;
            if (se !== exp_bit(k - 2, 8'h41, 7, 1'b1, 1'b0)) errs_e++;
            if (so !== exp_bit(k - 2, 8'h41, 7, 1'b1, 1'b1)) errs_o++;
            if (be === 1'b1) busy_e++;
            if (bo === 1'b1) busy_o++;
            if (dne === 1'b1) done_ke = k;
            if (dno === 1'b1) done_ko = k;
            if (k == 35) begin
                checks++; if (se !== 1'b0) $display("FAIL even_parity_bit got %b want 0", se); else passed++;
                checks++; if (so !== 1'b1) $display("FAIL odd_parity_bit got %b want 1", so); else passed++;
            end
        end
        ve = 1'b0; vo = 1'b0;
        checks++; if (errs_e != 0) $display("FAIL even_line got %0d bad cycles want 0", errs_e); else passed++;
        checks++; if (errs_o != 0) $display("FAIL odd_line got %0d bad cycles want 0", errs_o); else passed++;
        checks++; if (busy_e != 44) $display("FAIL even_frame_clocks got %0d want 44", busy_e); else passed++;
        checks++; if (busy_o != 44) $display("FAIL odd_frame_clocks got %0d want 44", busy_o); else passed++;
        checks++; if (done_ke != 45) $display("FAIL even_done_position got k=%0d want 45", done_ke); else passed++;
        checks++; if (done_ko != 45) $display("FAIL odd_done_position got k=%0d want 45", done_ko); else passed++;
    endtask

    task automatic test_same_edge();
        int errs = 0, bad_k = -1;
        logic want, bad_got = 1'b0, bad_want = 1'b0;
        exp_words[0] = 8'h3C; exp_words[1] = 8'hC3; exp_words[2] = 8'h5A;
        for (int k = 0; k < 136; k++) begin
            v8 = (k == 0) || (k == 1) || (k == 41);
            d8 = (k == 0) ? exp_words[0] : (k == 1) ? exp_words[1] : exp_words[2];
            @(posedge clk); #1;
            if (k == 40) begin
                checks++; if (c8 !== 3'd1) $display("FAIL same_edge_count_before got %0d want 1", c8); else passed++;
            end
            if (k == 41) begin
                checks++; if (c8 !== 3'd1) $display("FAIL same_edge_count_after got %0d want 1", c8); else passed++;
                checks++; if (dn8 !== 1'b1) $display("FAIL same_edge_at_boundary got done=%b want 1", dn8); else passed++;
            end
            if (k == 81) begin
                checks++; if (c8 !== 3'd0) $display("FAIL same_edge_count_drain got %0d want 0", c8); else passed++;
            end
            want = exp_stream(k, 3);
            if (s8 !== want) begin
                if (errs == 0) begin bad_k = k; bad_got = s8; bad_want = want; end
                errs++;
            end
        end
        v8 = 1'b0;
        checks++; if (errs != 0) $display("FAIL same_edge_line %0d bad cycles, first k=%0d got %b want %b", errs, bad_k, bad_got, bad_want); else passed++;
    endtask

    task automatic test_reset_mid();
        int errs = 0, bad_k = -1, done_n = 0;
        logic want, bad_got = 1'b0, bad_want = 1'b0;
        exp_words[0] = 8'h11; exp_words[1] = 8'h22; exp_words[2] = 8'h33;
        for (int k = 0; k <= 20; k++) begin
            v8 = (k < 3);
            d8 = exp_words[(k < 3) ? k : 0];
            @(posedge clk); #1;
        end
        v8 = 1'b0;
        checks++; if (s8 !== 1'b0) $display("FAIL midreset_line_before got %b want 0", s8); else passed++;
        checks++; if (c8 !== 3'd2) $display("FAIL midreset_count_before got %0d want 2", c8); else passed++;
        rst_n = 1'b0;
        #1;
        checks++; if (s8 !== 1'b1) $display("FAIL midreset_serial got %b want 1", s8); else passed++;
        checks++; if (b8 !== 1'b0) $display("FAIL midreset_busy got %b want 0", b8); else passed++;
        checks++; if (c8 !== 3'd0) $display("FAIL midreset_count got %0d want 0", c8); else passed++;
        checks++; if (r8 !== 1'b0) $display("FAIL midreset_ready got %b want 0", r8); else passed++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (r8 !== 1'b1) $display("FAIL midreset_ready_release got %b want 1", r8); else passed++;
        exp_words[0] = 8'hA5;
        for (int k = 0; k < 100; k++) begin
            v8 = (k == 0);
            d8 = 8'hA5;
            @(posedge clk); #1;
            want = exp_stream(k, 1);
            if (s8 !== want) begin
                if (errs == 0) begin bad_k = k; bad_got = s8; bad_want = want; end
                errs++;
            end
            if (dn8 === 1'b1) done_n++;
        end
        v8 = 1'b0;
        checks++; if (errs != 0) $display("FAIL midreset_clean_frame %0d bad cycles, first k=%0d got %b want %b", errs, bad_k, bad_got, bad_want); else passed++;
        checks++; if (done_n != 1) $display("FAIL midreset_done_pulses got %0d want 1", done_n); else passed++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_fifo_full();
        test_parity();
        test_same_edge();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached, checks done %0d want all", checks);
        $fatal(1);
    end

endmodule
